usb_rx_decoder: RTL
===================

// Module: usb_rx_decoder
// PURPOSE
//   Full-speed USB receive front end; the counterpart stage that consumes the d_plus/d_minus pair produced by the transmitter.
//   Synchronizes the bus, recovers bit timing, and decodes NRZI, bit stuffing, SYNC and EOP.
//   Emits decoded packet bytes as a valid-pulse stream to the downstream receive FIFO.
// PARAMETERS
//   CLKS_PER_BIT  8  system clocks per USB bit time; even, >= 4
//   IDLE_BITS     7  consecutive J bit times that return the ERROR state to IDLE
// PORTS
//   clk            in   1  system clock, rising edge
//   n_rst          in   1  synchronous, active-low reset
//   d_plus         in   1  USB D+ (asynchronous to clk)
//   d_minus        in   1  USB D- (asynchronous to clk)
//   rx_data        out  8  last decoded byte, LSB received first
//   rx_valid       out  1  1-cycle pulse; rx_data is new
//   rx_sop         out  1  1-cycle pulse; SYNC matched
//   rx_eop         out  1  1-cycle pulse; packet ended cleanly, byte aligned
//   rx_error       out  1  1-cycle pulse; stuff, sync or alignment error
//   rx_busy        out  1  high from SYNC start until IDLE is re-entered
// BEHAVIOUR
//   Interface: one clock; reset is synchronous and active-low (clk, n_rst).
//   Reset: all outputs 0. rx_data=8'h00. State=IDLE. Synchronizers preset to J (D+=1, D-=0).
//   Sync: two-flop synchronizer on each line. Line states: J=10, K=01, SE0=00. 11 is treated as SE0.
//   Bit timing:
//     - Any change of the synchronized line state clears the phase counter.
//     - A bit is sampled when phase == CLKS_PER_BIT/2 - 1.
//     - The counter wraps at CLKS_PER_BIT-1. With no edges, samples therefore repeat every CLKS_PER_BIT clocks.
//   NRZI: at each sample, the sampled state equals the previous sample -> bit 1; otherwise -> bit 0.
//   FSM:
//     IDLE
//       - First K after J -> SYNC; rx_busy=1.
//     SYNC
//       - Shift 8 decoded bits.
//       - Pattern 0000_0001 (the last bit is the second K) -> RECEIVE, with a 1-cycle rx_sop.
//       - Any other pattern, or SE0 -> ERROR.
//     RECEIVE
//       - Bit stuffing: after six consecutive 1s, the next bit is discarded if it is 0. If it is 1 -> ERROR.
//       - The ones-counter clears on any 0, including a stuffed 0.
//       - Data bits shift into an 8-bit register, LSB first.
//       - On the 8th kept bit, rx_data updates and rx_valid pulses on the following clk (latency 1 clk after the sample).
//       - SE0 sample with bit count 0 -> EOP.
//       - SE0 sample with bit count 1..7 -> ERROR.
//       - The first SE0 sample ends the byte stream; no partial byte is ever output.
//     EOP
//       - Requires a 2nd SE0 sample, then a J sample. rx_eop pulses on the clk after the J sample -> IDLE; rx_busy=0.
//       - A K at either sample -> ERROR.
//     ERROR
//       - rx_error pulses once on entry.
//       - Stays until IDLE_BITS consecutive J samples -> IDLE; rx_busy=0.
//   Exclusivity: rx_valid, rx_eop and rx_error never assert in the same cycle.
//     - The stuff-error check takes priority over the byte-complete check.
//     - A byte completing on the same sample as an error is not emitted.
//   Reset mid-packet: reset takes effect on the next clk and overrides all; the bus is then re-acquired from IDLE.
//     A packet in flight is ignored until the bus is J and a fresh K arrives.
//   Phase counter width: $clog2(CLKS_PER_BIT). Bit counter: 3 bits. Ones counter: 3 bits, saturating at 6.
// TESTING
//   T1 Basic: SYNC, byte 8'hA5, EOP (SE0, SE0, J) -> rx_sop, then rx_valid with rx_data=A5, then rx_eop. rx_error stays 0.
//   T2 Stuffing: byte 8'hFF with a stuffed 0 after the 6th one -> rx_data=FF exactly once; a bit counter check confirms no extra bit.
//   T3 Stuff error: seven 1s with no stuffed 0 -> rx_error 1 pulse, no rx_valid. After 7 J bits, rx_busy=0.
//   T4 Misaligned EOP: SYNC, 8'h3C, 4 more bits, SE0 -> one rx_valid (3C), then rx_error. rx_eop never asserts.
//   T5 Jitter: edges shifted +/-1 clk on every bit of 8'h5A, 8'hC3 -> both bytes received correctly.
//   T6 Reset mid-packet: n_rst=0 for 1 clk after 3 bits of a byte -> outputs 0. The remainder of that packet produces no pulses; the next packet decodes normally.

Source files
------------

// File: rtl/usb_rx_decoder.sv
// Full-speed USB receive front end: line synchronizer, bit-timing recovery,
// NRZI / bit-stuff / SYNC / EOP decode, and a pulse-qualified byte stream.
module usb_rx_decoder #(
    parameter int CLKS_PER_BIT = 8,
    parameter int IDLE_BITS    = 7
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_plus,
    input  logic       d_minus,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_sop,
    output logic       rx_eop,
    output logic       rx_error,
    output logic       rx_busy
);

    localparam int PW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(IDLE_BITS + 1);
    localparam logic [PW-1:0] PHASE_SAMPLE = PW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [PW-1:0] PHASE_LAST   = PW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDLE_DONE    = IW'(IDLE_BITS);
    // SYNC 0000_0001 in arrival order, as it lands in an LSB-first shifter
    localparam logic [7:0]    SYNC_PATTERN = 8'h80;

    typedef enum logic [1:0] {LINE_J, LINE_K, LINE_SE0} line_t;
    typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_RECEIVE, ST_EOP1, ST_EOP2, ST_ERROR} state_t;

    logic          dp_meta_q, dp_meta_d, dp_sync_q, dp_sync_d;
    logic          dm_meta_q, dm_meta_d, dm_sync_q, dm_sync_d;
    line_t         line_now, line_q, line_d, prev_q, prev_d;
    logic [PW-1:0] phase_q, phase_d;
    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d, rx_data_q, rx_data_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d, ones_q, ones_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic          armed_q, armed_d;
    logic          rx_valid_q, rx_valid_d, rx_sop_q, rx_sop_d, rx_eop_q, rx_eop_d;
    logic          rx_error_q, rx_error_d, rx_busy_q, rx_busy_d;
    logic          sample, bit_now;

    always_comb begin
        case ({dp_sync_q, dm_sync_q})
            2'b10:   line_now = LINE_J;
            2'b01:   line_now = LINE_K;
            default: line_now = LINE_SE0;
        endcase
    end

    assign sample  = (phase_q == PHASE_SAMPLE);
    assign bit_now = (line_q == prev_q);

    always_comb begin
        // NOTE: every _d starts from a hold or default value, so no branch can infer a latch.
        dp_meta_d  = d_plus;
        dm_meta_d  = d_minus;
        dp_sync_d  = dp_meta_q;
        dm_sync_d  = dm_meta_q;
        line_d     = line_now;
        prev_d     = prev_q;
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        ones_d     = ones_q;
        idle_cnt_d = idle_cnt_q;
        armed_d    = armed_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_sop_d   = 1'b0;
        rx_eop_d   = 1'b0;
        rx_error_d = 1'b0;

        if (line_now != line_q || phase_q == PHASE_LAST) phase_d = '0;
        else                                             phase_d = phase_q + 1'b1;

        if (sample) begin
            prev_d = line_q;
            if (line_q != LINE_J)             idle_cnt_d = '0;
            else if (idle_cnt_q != IDLE_DONE) idle_cnt_d = idle_cnt_q + 1'b1;
            // after reset, a packet already in flight is ignored until the bus idles
            if (idle_cnt_d == IDLE_DONE) armed_d = 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (armed_q && line_q == LINE_K && prev_q == LINE_J) begin
                        state_d   = ST_SYNC;
                        shift_d   = 8'h00;
                        bit_cnt_d = 3'd1;
                    end
                end
                ST_SYNC: begin
                    if (line_q == LINE_SE0) begin
                        state_d = ST_ERROR;
                    end else begin
                        shift_d   = {bit_now, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (shift_d == SYNC_PATTERN) begin
                                state_d  = ST_RECEIVE;
                                rx_sop_d = 1'b1;
                                ones_d   = 3'd0;
                            end else begin
                                state_d = ST_ERROR;
                            end
                        end
                    end
                end
                ST_RECEIVE: begin
                    if (line_q == LINE_SE0) begin
                        state_d = (bit_cnt_q == 3'd0) ? ST_EOP1 : ST_ERROR;
                    end else if (ones_q == 3'd6) begin
                        if (bit_now) state_d = ST_ERROR;
                        else         ones_d  = 3'd0;
                    end else begin
                        ones_d    = bit_now ? ones_q + 3'd1 : 3'd0;
                        shift_d   = {bit_now, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d  = shift_d;
                            rx_valid_d = 1'b1;
                        end
                    end
                end
                ST_EOP1: begin
                    state_d = (line_q == LINE_SE0) ? ST_EOP2 : ST_ERROR;
                end
                ST_EOP2: begin
                    if (line_q == LINE_J) begin
                        state_d  = ST_IDLE;
                        rx_eop_d = 1'b1;
                    end else if (line_q == LINE_K) begin
                        state_d = ST_ERROR;
                    end
                end
                ST_ERROR: begin
                    if (idle_cnt_d == IDLE_DONE) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase

            if (state_d == ST_ERROR && state_q != ST_ERROR) begin
                rx_error_d = 1'b1;
                idle_cnt_d = '0;
            end
        end

        rx_busy_d = (state_d != ST_IDLE);
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            // NOTE: the line flops reset to J rather than zero, so an idle bus shows no edge after reset.
            dp_meta_q  <= 1'b1;
            dp_sync_q  <= 1'b1;
            dm_meta_q  <= 1'b0;
            dm_sync_q  <= 1'b0;
            line_q     <= LINE_J;
            prev_q     <= LINE_J;
            phase_q    <= '0;
            state_q    <= ST_IDLE;
            shift_q    <= 8'h00;
            bit_cnt_q  <= 3'd0;
            ones_q     <= 3'd0;
            idle_cnt_q <= '0;
            armed_q    <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_sop_q   <= 1'b0;
            rx_eop_q   <= 1'b0;
            rx_error_q <= 1'b0;
            rx_busy_q  <= 1'b0;
        end else begin
            dp_meta_q  <= dp_meta_d;
            dp_sync_q  <= dp_sync_d;
            dm_meta_q  <= dm_meta_d;
            dm_sync_q  <= dm_sync_d;
            line_q     <= line_d;
            prev_q     <= prev_d;
            phase_q    <= phase_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            ones_q     <= ones_d;
            idle_cnt_q <= idle_cnt_d;
            armed_q    <= armed_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_sop_q   <= rx_sop_d;
            rx_eop_q   <= rx_eop_d;
            rx_error_q <= rx_error_d;
            rx_busy_q  <= rx_busy_d;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_sop   = rx_sop_q;
    assign rx_eop   = rx_eop_q;
    assign rx_error = rx_error_q;
    assign rx_busy  = rx_busy_q;

endmodule
